uart_tx_frame_engine: RTL and testbench

- Parametrised UART transmit engine; successor to the fixed 7/8-bit parity generator used by the transmit path.
- Accepts one data word per handshake and computes parity over a runtime-selectable width (5..MAX_DATA_W).
- Serialises start, data (LSB first), optional parity and 1 or 2 stop bits at a programmable bit period.
- Sits between the TX register interface and the serial pin.

---
 rtl/uart_tx_frame_engine.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_frame_engine: UART TX serialiser, runtime length/parity/stop, optional
// UART_TX_HOLD_REG_EN one-entry holding register for gapless frames. Rev 1.0
// ============================================================================
module uart_tx_frame_engine #(
  parameter int MAX_DATA_W = 8,
  parameter int BAUD_W     = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BAUD_W-1:0]     baud_k,
  input  logic [3:0]            data_len,
  input  logic [2:0]            par_mode,
  input  logic                  stop2,
  input  logic                  ld_valid,
  input  logic [MAX_DATA_W-1:0] ld_data,
  output logic                  tx_ready,
  output logic                  tx_done,
  output logic                  busy,
  output logic                  tx
);

  localparam logic [3:0]        MIN_LEN = 4'd5;
  localparam logic [3:0]        MAX_LEN = 4'(MAX_DATA_W);
  localparam logic [BAUD_W-1:0] CNT_ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

  // Everything a frame needs, captured at accept so later config edits are inert.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic [3:0]            len;
    logic [BAUD_W-1:0]     baud;
    logic                  pen;
    logic                  par_bit;
    logic                  stop2;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  frame_t                cur, cur_n, in_frame, load_frame;
  logic [BAUD_W-1:0]     bit_cnt, bit_cnt_n;
  logic [3:0]            bit_idx, bit_idx_n;
  logic [MAX_DATA_W-1:0] shift, shift_n;
  logic                  stop_idx, stop_idx_n;
  logic                  tx_q, tx_n;
  logic                  accept, last_tick, frame_end, load;

  always_comb begin
    in_frame = '0;
    if (data_len < MIN_LEN)
      in_frame.len = MIN_LEN;
    else if (data_len > MAX_LEN)
      in_frame.len = MAX_LEN;
    else
      in_frame.len = data_len;
    for (int i = 0; i < MAX_DATA_W; i++)
      in_frame.data[i] = ld_data[i] & (i < int'(in_frame.len));
    in_frame.baud    = baud_k;
    in_frame.stop2   = stop2;
    in_frame.pen     = par_mode[2];
    in_frame.par_bit = par_mode[1] ? par_mode[0] : ((^in_frame.data) ^ par_mode[0]);
  end

  assign accept    = ld_valid & tx_ready;
  assign last_tick = (bit_cnt == cur.baud);
  assign frame_end = (state == S_STOP) & last_tick & (stop_idx == cur.stop2);

`ifdef UART_TX_HOLD_REG_EN
  frame_t hold;
  logic   hold_full;
  logic   direct;

  assign tx_ready   = ~hold_full;
  // An incoming word bypasses the holding register when the engine is free for it now.
  assign direct     = accept & ((state == S_IDLE) | (frame_end & ~hold_full));
  assign load       = direct | (frame_end & hold_full);
  assign load_frame = (frame_end & hold_full) ? hold : in_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept & ~direct) begin
      hold      <= in_frame;
      hold_full <= 1'b1;
    end else if (frame_end & hold_full) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign tx_ready   = (state == S_IDLE);
  assign load       = accept;
  assign load_frame = in_frame;
`endif

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    stop_idx_n = stop_idx;
    tx_n       = 1'b1;

    if (state != S_IDLE)
      bit_cnt_n = last_tick ? '0 : bit_cnt + CNT_ONE;

    case (state)
      S_START: begin
        if (last_tick) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (last_tick) begin
          shift_n = shift >> 1;
          if (bit_idx == cur.len - 4'd1) begin
            state_n    = cur.pen ? S_PARITY : S_STOP;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (last_tick) begin
          state_n    = S_STOP;
          stop_idx_n = 1'b0;
        end
      end
      S_STOP: begin
        if (frame_end)
          state_n = S_IDLE;
        else if (last_tick)
          stop_idx_n = 1'b1;
      end
      default: ;
    endcase

    if (load) begin
      state_n    = S_START;
      cur_n      = load_frame;
      shift_n    = load_frame.data;
      bit_cnt_n  = '0;
      bit_idx_n  = '0;
      stop_idx_n = 1'b0;
    end

    // Line level is decoded from the next state so tx itself is a plain flop.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = cur_n.par_bit;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cur      <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      stop_idx <= stop_idx_n;
      tx_q     <= tx_n;
    end
  end

  assign tx      = tx_q;
  assign busy    = (state != S_IDLE);
  assign tx_done = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_frame_engine: randomized + directed frame checks against a
// bit-list model of the UART frame. Rev 1.0
// ============================================================================
module tb_uart_tx_frame_engine;

  localparam int MAX_DATA_W = 8;
  localparam int BAUD_W     = 19;
`ifdef UART_TX_HOLD_REG_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [BAUD_W-1:0]     baud_k = '0;
  logic [3:0]            data_len = 4'd8;
  logic [2:0]            par_mode = 3'd0;
  logic                  stop2 = 1'b0;
  logic                  ld_valid = 1'b0;
  logic [MAX_DATA_W-1:0] ld_data = '0;
  logic                  tx_ready, tx_done, busy, tx;

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] cap_tx, cap_done, cap_busy, cap_rdy;
  logic [255:0] exp_tx, exp_done, exp_busy, exp_rdy;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(.MAX_DATA_W(MAX_DATA_W), .BAUD_W(BAUD_W)) dut (
    .clk(clk), .reset(reset), .baud_k(baud_k), .data_len(data_len),
    .par_mode(par_mode), .stop2(stop2), .ld_valid(ld_valid), .ld_data(ld_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .tx(tx)
  );

  task automatic exp_clear();
    exp_tx = '1; exp_done = '0; exp_busy = '0; exp_rdy = '1;
  endtask

  // Reference frame: list of line levels per bit, each stretched to bk+1 clocks.
  task automatic build_exp(input logic [7:0] d, input logic [3:0] dl, input logic [2:0] pm,
                           input logic s2, input int bk, input int off, output int nclk);
    bit q[$];
    int len, ones;
    bit pb;
    len = (dl < 4'd5) ? 5 : ((dl > 4'd8) ? 8 : int'(dl));
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm[2]) begin
      case (pm[1:0])
        2'b00:   pb = ((ones % 2) == 1);
        2'b01:   pb = ((ones % 2) == 0);
        2'b10:   pb = 1'b0;
        default: pb = 1'b1;
      endcase
      q.push_back(pb);
    end
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    nclk = q.size() * (bk + 1);
    for (int c = 0; c < nclk; c++) begin
      exp_tx[off + c]   = q[c / (bk + 1)];
      exp_busy[off + c] = 1'b1;
      exp_rdy[off + c]  = HOLD;
    end
    exp_done[off + nclk - 1] = 1'b1;
  endtask

  // Starts at a negedge; captures ncap samples, one per negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic [3:0] dl, input logic [2:0] pm,
                      input logic s2, input int bk, input bit scramble, input int ncap);
    int w = 0;
    while (!tx_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_wait tx_ready got 0 required 1");
    end
    ld_data = d; data_len = dl; par_mode = pm; stop2 = s2; baud_k = BAUD_W'(bk); ld_valid = 1'b1;
    cap_tx = '1; cap_done = '0; cap_busy = '0; cap_rdy = '1;
    @(posedge clk);
    for (int n = 0; n < ncap; n++) begin
      @(negedge clk);
      cap_tx[n] = tx; cap_done[n] = tx_done; cap_busy[n] = busy; cap_rdy[n] = tx_ready;
      if (n == 0) ld_valid = 1'b0;
      if (scramble) begin
        ld_data = 8'($urandom); data_len = 4'($urandom); par_mode = 3'($urandom);
        stop2 = 1'($urandom); baud_k = BAUD_W'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({tx, busy, tx_ready, tx_done} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_state {tx,busy,ready,done} got %b required 1010", {tx, busy, tx_ready, tx_done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    exp_clear(); build_exp(8'hA5, 4'd8, 3'b100, 1'b0, 3, 0, n);
    send(8'hA5, 4'd8, 3'b100, 1'b0, 3, 1'b0, n + 2);
    tests_run++;
    if (cap_tx !== exp_tx) begin tests_failed++; $display("FAIL basic_tx got %h required %h", cap_tx, exp_tx); end
    tests_run++;
    if (cap_done !== exp_done) begin tests_failed++; $display("FAIL basic_done got %h required %h", cap_done, exp_done); end
    tests_run++;
    if (cap_busy !== exp_busy) begin tests_failed++; $display("FAIL basic_busy got %h required %h", cap_busy, exp_busy); end
    tests_run++;
    if (cap_rdy !== exp_rdy) begin tests_failed++; $display("FAIL basic_ready got %h required %h", cap_rdy, exp_rdy); end
  endtask

  task automatic test_short_frame();
    int n;
    exp_clear(); build_exp(8'hFF, 4'd5, 3'b101, 1'b1, 0, 0, n);
    send(8'hFF, 4'd5, 3'b101, 1'b1, 0, 1'b0, n + 2);
    tests_run++;
    if (cap_tx !== exp_tx) begin tests_failed++; $display("FAIL short_tx got %h required %h", cap_tx, exp_tx); end
    tests_run++;
    if (cap_done !== exp_done) begin tests_failed++; $display("FAIL short_done got %h required %h", cap_done, exp_done); end
  endtask

  task automatic test_parity_modes();
    logic [2:0] modes [3] = '{3'b111, 3'b110, 3'b000};
    int n;
    foreach (modes[m]) begin
      exp_clear(); build_exp(8'h00, 4'd7, modes[m], 1'b0, 1, 0, n);
      send(8'h00, 4'd7, modes[m], 1'b0, 1, 1'b0, n + 2);
      tests_run++;
      if (cap_tx !== exp_tx) begin
        tests_failed++; $display("FAIL parity_mode_%b_tx got %h required %h", modes[m], cap_tx, exp_tx);
      end
      tests_run++;
      if (cap_done !== exp_done) begin
        tests_failed++; $display("FAIL parity_mode_%b_done got %h required %h", modes[m], cap_done, exp_done);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [3:0] lens [2] = '{4'd2, 4'd15};
    int n;
    foreach (lens[k]) begin
      exp_clear(); build_exp(8'hFF, lens[k], 3'b100, 1'b0, 1, 0, n);
      send(8'hFF, lens[k], 3'b100, 1'b0, 1, 1'b0, n + 2);
      tests_run++;
      if (cap_tx !== exp_tx) begin
        tests_failed++; $display("FAIL len_clamp_%0d_tx got %h required %h", lens[k], cap_tx, exp_tx);
      end
      tests_run++;
      if (cap_busy !== exp_busy) begin
        tests_failed++; $display("FAIL len_clamp_%0d_busy got %h required %h", lens[k], cap_busy, exp_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, gap, ncap;
    bit drop;
    gap = HOLD ? 0 : 1;
    exp_clear();
    build_exp(8'h11, 4'd8, 3'b000, 1'b0, 1, 0, n1);
    build_exp(8'h22, 4'd8, 3'b000, 1'b0, 1, n1 + gap, n2);
    ncap = n1 + gap + n2 + 2;
    cap_tx = '1; cap_done = '0; cap_busy = '0; cap_rdy = '1;
    ld_data = 8'h11; data_len = 4'd8; par_mode = 3'b000; stop2 = 1'b0; baud_k = BAUD_W'(1);
    ld_valid = 1'b1;
    @(posedge clk);
    drop = 1'b0;
    for (int n = 0; n < ncap; n++) begin
      @(negedge clk);
      cap_tx[n] = tx; cap_done[n] = tx_done; cap_busy[n] = busy;
      if (n == 0) ld_data = 8'h22;
      if (drop) ld_valid = 1'b0;
      drop = ld_valid && tx_ready;
    end
    ld_valid = 1'b0;
    tests_run++;
    if (cap_tx !== exp_tx) begin tests_failed++; $display("FAIL b2b_tx got %h required %h", cap_tx, exp_tx); end
    tests_run++;
    if (cap_done !== exp_done) begin tests_failed++; $display("FAIL b2b_done got %h required %h", cap_done, exp_done); end
    tests_run++;
    if (cap_busy !== exp_busy) begin tests_failed++; $display("FAIL b2b_busy got %h required %h", cap_busy, exp_busy); end
  endtask

  task automatic test_random();
    logic [7:0] d; logic [3:0] dl; logic [2:0] pm; logic s2;
    int bk, n;
    for (int k = 0; k < 25; k++) begin
      d = 8'($urandom); dl = 4'($urandom); pm = 3'($urandom); s2 = 1'($urandom);
      bk = int'($urandom_range(0, 3));
      exp_clear(); build_exp(d, dl, pm, s2, bk, 0, n);
      send(d, dl, pm, s2, bk, 1'b1, n + 2);
      tests_run++;
      if (cap_tx !== exp_tx || cap_done !== exp_done || cap_busy !== exp_busy || cap_rdy !== exp_rdy) begin
        tests_failed++;
        $display("FAIL random_%0d d=%h len=%0d par=%b s2=%b bk=%0d tx got %h required %h done got %h required %h",
                 k, d, dl, pm, s2, bk, cap_tx, exp_tx, cap_done, exp_done);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    send(8'hA5, 4'd8, 3'b100, 1'b0, 3, 1'b0, 12);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({tx, busy, tx_ready, tx_done} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_mid_frame {tx,busy,ready,done} got %b required 1010", {tx, busy, tx_ready, tx_done});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_clear(); build_exp(8'h3C, 4'd8, 3'b100, 1'b0, 3, 0, n);
    send(8'h3C, 4'd8, 3'b100, 1'b0, 3, 1'b0, n + 2);
    tests_run++;
    if (cap_tx !== exp_tx || cap_done !== exp_done) begin
      tests_failed++;
      $display("FAIL after_reset_frame tx got %h required %h done got %h required %h",
               cap_tx, exp_tx, cap_done, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_parity_modes();
    test_len_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
